c_tile_accumulator: RTL and testbench



---
 rtl/c_tile_accumulator_if.sv | 32 +++
 rtl/c_tile_accumulator.sv | 155 +++++++++++++++
 tb/tb_c_tile_accumulator.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/c_tile_accumulator_if.sv
// Bundle of the partial-tile input handshake, the completed-tile output
// handshake and the status signals of the C tile accumulator.
interface c_tile_accumulator_if #(
    parameter int M          = 3,
    parameter int DATA_WIDTH = 64
);
    logic                           in_valid;
    logic                           in_ready;
    logic                           in_first;
    logic                           in_last;
    logic [7:0]                     in_rows;
    logic [7:0]                     in_cols;
    logic [DATA_WIDTH*M*M-1:0]      in_tile_flat;
    logic                           out_valid;
    logic                           out_ready;
    logic [DATA_WIDTH*M*M-1:0]      out_tile_flat;
    logic                           out_overflow;
    logic                           busy;
    logic [7:0]                     partial_count;

    // Accumulator side
    modport slave (
        input  in_valid, in_first, in_last, in_rows, in_cols, in_tile_flat, out_ready,
        output in_ready, out_valid, out_tile_flat, out_overflow, busy, partial_count
    );

    // Matmul engine / write-back side
    modport master (
        output in_valid, in_first, in_last, in_rows, in_cols, in_tile_flat, out_ready,
        input  in_ready, out_valid, out_tile_flat, out_overflow, busy, partial_count
    );
endinterface

// File: rtl/c_tile_accumulator.sv
// C tile accumulator: sums partial M x M tiles from the matmul engine one
// element per cycle into a resident accumulator, then offers the finished
// tile to write-back over a valid/ready handshake.
module c_tile_accumulator #(
    parameter int M          = 3,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    c_tile_accumulator_if.slave   bus
);
    localparam int NUM  = M * M;
    localparam int IDXW = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM - 1);
    localparam logic [7:0]      M_COUNT  = 8'(M);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_OUTPUT = 2'd2;

    logic [1:0]                   r_state;
    logic [IDXW-1:0]              r_idx;
    logic [7:0]                   r_row;
    logic [7:0]                   r_col;
    logic [7:0]                   r_rows;
    logic [7:0]                   r_cols;
    logic                         r_first;
    logic                         r_last;
    logic [DATA_WIDTH-1:0]        r_tile [NUM];
    logic [DATA_WIDTH-1:0]        r_acc  [NUM];
    logic                         r_overflow;
    logic [7:0]                   r_count;

    logic                         w_accept;
    logic                         w_lastElem;
    logic [7:0]                   w_rowsClamped;
    logic [7:0]                   w_colsClamped;
    logic [DATA_WIDTH-1:0]        w_elem;
    logic [DATA_WIDTH-1:0]        w_contrib;
    logic [DATA_WIDTH-1:0]        w_base;
    logic [DATA_WIDTH-1:0]        w_sum;
    logic                         w_overflow;

    assign w_accept      = bus.in_valid && (r_state == S_IDLE);
    assign w_lastElem    = (r_idx == LAST_IDX);
    assign w_rowsClamped = (bus.in_rows > M_COUNT) ? M_COUNT : bus.in_rows;
    assign w_colsClamped = (bus.in_cols > M_COUNT) ? M_COUNT : bus.in_cols;

    // Elements outside the valid rows/cols window contribute nothing; the
    // first tile of a group starts from zero instead of the old contents.
    assign w_elem     = r_tile[r_idx];
    assign w_contrib  = ((r_row < r_rows) && (r_col < r_cols)) ? w_elem : '0;
    assign w_base     = r_first ? '0 : r_acc[r_idx];
    assign w_sum      = w_base + w_contrib;
    assign w_overflow = (w_base[DATA_WIDTH-1] == w_contrib[DATA_WIDTH-1]) &&
                        (w_sum[DATA_WIDTH-1] != w_base[DATA_WIDTH-1]);

    assign bus.in_ready      = (r_state == S_IDLE);
    assign bus.out_valid     = (r_state == S_OUTPUT);
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.out_overflow  = r_overflow;
    assign bus.partial_count = r_count;

    // Flatten the accumulator onto the output bus with the input packing
    always_comb begin
        bus.out_tile_flat = '0;
        for (int e = 0; e < NUM; e++) begin
            bus.out_tile_flat[e*DATA_WIDTH +: DATA_WIDTH] = r_acc[e];
        end
    end

    // Control FSM: accept a tile, walk its elements, then publish or return
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_accept) r_state <= S_ACCUM;
                S_ACCUM:  if (w_lastElem) r_state <= r_last ? S_OUTPUT : S_IDLE;
                S_OUTPUT: if (bus.out_ready) r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Capture the offered tile and its qualifiers at acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_rows  <= '0;
            r_cols  <= '0;
            for (int e = 0; e < NUM; e++) begin
                r_tile[e] <= '0;
            end
        end else if (w_accept) begin
            r_first <= bus.in_first;
            r_last  <= bus.in_last;
            r_rows  <= w_rowsClamped;
            r_cols  <= w_colsClamped;
            for (int e = 0; e < NUM; e++) begin
                r_tile[e] <= bus.in_tile_flat[e*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Element walker: linear index plus row/col kept alongside to avoid a divider
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            r_idx <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (r_state == S_ACCUM) begin
            r_idx <= r_idx + 1'b1;
            if (r_col == M_COUNT - 8'd1) begin
                r_col <= '0;
                r_row <= r_row + 8'd1;
            end else begin
                r_col <= r_col + 8'd1;
            end
        end
    end

    // Group bookkeeping: saturating partial count and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            if (bus.in_first) begin
                r_count    <= 8'd1;
                r_overflow <= 1'b0;
            end else if (r_count != 8'd255) begin
                r_count <= r_count + 8'd1;
            end
        end else if ((r_state == S_ACCUM) && w_overflow) begin
            r_overflow <= 1'b1;
        end
    end

    // Accumulate one element per cycle, wrapping at the element width
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < NUM; e++) begin
                r_acc[e] <= '0;
            end
        end else if (r_state == S_ACCUM) begin
            r_acc[r_idx] <= w_sum;
        end
    end
endmodule

// File: tb/tb_c_tile_accumulator.sv
// Self-checking bench for c_tile_accumulator: directed scenarios followed by
// randomized tile groups, all checked against an arithmetic reference model.
module tb_c_tile_accumulator;
   localparam int M   = 3;
   localparam int DW  = 64;
   localparam int NUM = M * M;
   localparam int FW  = DW * NUM;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   c_tile_accumulator_if #(.M(M), .DATA_WIDTH(DW)) bus ();

   c_tile_accumulator #(.M(M), .DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int testCount = 0;
   int failCount = 0;

   longint      modelAcc [NUM];
   bit          modelOvf;
   int          modelCount;
   logic [63:0] tileIn [NUM];

   // Count one comparison and report it if the observed value is wrong
   task automatic checkOutput(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model contents packed the same way as the output bus
   function automatic logic [FW-1:0] modelFlat();
      logic [FW-1:0] f;
      f = '0;
      for (int e = 0; e < NUM; e++) f[e*DW +: DW] = modelAcc[e];
      return f;
   endfunction

   function automatic logic [FW-1:0] packTile();
      logic [FW-1:0] f;
      f = '0;
      for (int e = 0; e < NUM; e++) f[e*DW +: DW] = tileIn[e];
      return f;
   endfunction

   // Reference: add the window-masked tile with exact arithmetic, flag results out of 64-bit range
   task automatic modelApply(input bit first, input int rows, input int cols);
      int rc;
      int cc;
      longint base;
      longint contrib;
      logic signed [64:0] wide;
      rc = (rows > M) ? M : rows;
      cc = (cols > M) ? M : cols;
      if (first) begin
         modelOvf = 0;
         modelCount = 1;
      end else if (modelCount < 255) begin
         modelCount = modelCount + 1;
      end
      for (int e = 0; e < NUM; e++) begin
         contrib = ((e / M) < rc && (e % M) < cc) ? longint'(tileIn[e]) : 0;
         base = first ? 0 : modelAcc[e];
         wide = 65'(base) + 65'(contrib);
         if (wide != 65'(longint'(wide))) modelOvf = 1;
         modelAcc[e] = longint'(wide);
      end
   endtask

   task automatic modelReset();
      for (int e = 0; e < NUM; e++) modelAcc[e] = 0;
      modelOvf = 0;
      modelCount = 0;
   endtask

   // Wait (bounded) for in_ready at a falling edge; returns 0 on timeout
   task automatic waitReady(output bit ok);
      int n;
      n = 0;
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      ok = bus.in_ready;
      if (!ok) checkOutput("readyTimeout", 0, 1);
   endtask

   // Offer one partial tile, follow it through ACCUM and, if last, through OUTPUT
   task automatic applyStimulus(input bit first, input bit last, input logic [7:0] rows,
                                input logic [7:0] cols, input int holdCycles);
      bit ok;
      bit windowOk;
      logic [FW-1:0] heldTile;
      waitReady(ok);
      if (!ok) return;
      bus.in_valid     = 1'b1;
      bus.in_first     = first;
      bus.in_last      = last;
      bus.in_rows      = rows;
      bus.in_cols      = cols;
      bus.in_tile_flat = packTile();
      @(posedge clk);
      modelApply(first, int'(rows), int'(cols));
      windowOk = 1'b1;
      for (int i = 0; i < NUM; i++) begin
         @(negedge clk);
         if (i == 0) bus.in_valid = 1'b0;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b1) windowOk = 1'b0;
      end
      checkOutput("accumWindow", FW'(windowOk), 1);
      @(negedge clk);
      checkOutput("outValidAfterAccum", FW'(bus.out_valid), FW'(last));
      checkOutput("inReadyAfterAccum", FW'(bus.in_ready), FW'(!last));
      checkOutput("partialCount", FW'(bus.partial_count), FW'(modelCount));
      checkOutput("overflow", FW'(bus.out_overflow), FW'(modelOvf));
      checkOutput("tile", bus.out_tile_flat, modelFlat());
      if (last) begin
         heldTile = bus.out_tile_flat;
         for (int h = 0; h < holdCycles; h++) begin
            bus.in_valid = h[0];
            bus.in_first = 1'b1;
            bus.in_tile_flat = {NUM{$urandom(), $urandom()}};
            @(negedge clk);
            windowOk = (bus.out_valid === 1'b1) && (bus.in_ready === 1'b0) &&
                       (bus.out_tile_flat === heldTile);
            checkOutput("outputHold", FW'(windowOk), 1);
         end
         bus.in_valid = 1'b0;
         if (holdCycles > 0) checkOutput("holdCount", FW'(bus.partial_count), FW'(modelCount));
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;
         checkOutput("outValidDrop", FW'(bus.out_valid), 0);
         checkOutput("inReadyBack", FW'(bus.in_ready), 1);
      end
   endtask

   task automatic fillTile(input longint v);
      for (int e = 0; e < NUM; e++) tileIn[e] = v;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_inReady"}, FW'(bus.in_ready), 1);
      checkOutput({tag, "_outValid"}, FW'(bus.out_valid), 0);
      checkOutput({tag, "_busy"}, FW'(bus.busy), 0);
      checkOutput({tag, "_count"}, FW'(bus.partial_count), 0);
      checkOutput({tag, "_ovf"}, FW'(bus.out_overflow), 0);
      checkOutput({tag, "_tile"}, bus.out_tile_flat, '0);
   endtask

   initial begin
      bit ok;
      reset            = 1'b1;
      bus.in_valid     = 1'b0;
      bus.in_first     = 1'b0;
      bus.in_last      = 1'b0;
      bus.in_rows      = 8'd0;
      bus.in_cols      = 8'd0;
      bus.in_tile_flat = '0;
      bus.out_ready    = 1'b0;
      modelReset();
      repeat (2) @(negedge clk);
      checkResetValues("reset");
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] single-pass tile 1..9");
      for (int e = 0; e < NUM; e++) tileIn[e] = 64'(e + 1);
      applyStimulus(1, 1, 8'd3, 8'd3, 0);

      $display("[TB] two-pass group 5 + 7");
      fillTile(5);
      applyStimulus(1, 0, 8'd3, 8'd3, 0);
      fillTile(7);
      applyStimulus(0, 1, 8'd3, 8'd3, 0);

      $display("[TB] partial window and clamped window");
      fillTile(4);
      applyStimulus(1, 1, 8'd2, 8'd1, 0);
      applyStimulus(1, 1, 8'd9, 8'd9, 0);

      $display("[TB] signed overflow");
      fillTile(0);
      tileIn[0] = 64'h7FFF_FFFF_FFFF_FFFF;
      applyStimulus(1, 0, 8'd3, 8'd3, 0);
      fillTile(0);
      tileIn[0] = 64'd1;
      applyStimulus(0, 1, 8'd3, 8'd3, 0);
      checkOutput("ovfElem0", FW'(bus.out_tile_flat[63:0]), FW'(64'h8000_0000_0000_0000));
      checkOutput("ovfFlagStays", FW'(bus.out_overflow), 1);
      fillTile(1);
      applyStimulus(1, 1, 8'd3, 8'd3, 0);

      $display("[TB] output back-pressure");
      fillTile(-3);
      applyStimulus(1, 1, 8'd3, 8'd3, 5);

      $display("[TB] reset during accumulation");
      waitReady(ok);
      if (ok) begin
         fillTile(6);
         bus.in_valid = 1'b1;
         bus.in_first = 1'b1;
         bus.in_last  = 1'b1;
         bus.in_rows  = 8'd3;
         bus.in_cols  = 8'd3;
         bus.in_tile_flat = packTile();
         @(posedge clk);
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
         end
         reset = 1'b1;
         #1;
         modelReset();
         checkResetValues("midReset");
         @(negedge clk);
         reset = 1'b0;
         @(negedge clk);
      end
      fillTile(2);
      applyStimulus(1, 1, 8'd3, 8'd3, 0);

      $display("[TB] randomized groups");
      for (int n = 0; n < 40; n++) begin
         bit rFirst;
         bit rLast;
         rFirst = (n == 0) || ($urandom_range(0, 3) == 0);
         rLast  = ($urandom_range(0, 2) == 0);
         for (int e = 0; e < NUM; e++) begin
            if ($urandom_range(0, 1) == 0) tileIn[e] = {$urandom(), $urandom()};
            else tileIn[e] = 64'(longint'($urandom_range(0, 200)) - 100);
         end
         applyStimulus(rFirst, rLast, 8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)),
                       int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end
endmodule
